// File: rtl/gray_decode_monitor.sv
// gray_decode_monitor: samples a Gray bus, decodes it to binary and checks each step for lock/error tracking
module gray_decode_monitor #(
    parameter int N          = 8,
    parameter int RESYNC_LEN = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic [N-1:0]         gray_in,
    input  logic                 clr_err,
    output logic [N-1:0]         bin_out,
    output logic                 bin_valid,
    output logic                 step_ok,
    output logic                 wrap,
    output logic                 hold,
    output logic                 step_err,
    output logic                 locked,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
);
    typedef enum logic [1:0] {ACQ, TRACK, FAULT} state_t;
    localparam int GW = $clog2(RESYNC_LEN + 1);
    localparam logic [GW-1:0] RUN_LAST = GW'(RESYNC_LEN - 1);
    state_t state, state_n;
    logic [GW-1:0] good_run, good_run_n;
    logic [N-1:0] g_q, b, prev_bin, delta;
    logic v1, cls, is_hold, is_step, is_err;
    always_comb begin
        for (int i = 0; i < N; i++) b[i] = ^(g_q >> i);
    end
    assign delta   = b - prev_bin;
    assign cls     = v1 && state != ACQ;
    assign is_hold = cls && delta == '0;
    assign is_step = cls && delta == N'(1);
    assign is_err  = cls && !is_hold && !is_step;
    assign locked  = state == TRACK;
    always_comb begin
        state_n    = state;
        good_run_n = good_run;
        if (v1) begin
            if (state == ACQ) begin
                state_n = TRACK;
            end else if (is_err) begin
                state_n    = FAULT;
                good_run_n = '0;
            end else if (state == FAULT && is_step) begin
                state_n    = good_run == RUN_LAST ? TRACK : FAULT;
                good_run_n = good_run == RUN_LAST ? '0 : good_run + GW'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACQ;
            good_run   <= '0;
            g_q        <= '0;
            v1         <= 1'b0;
            prev_bin   <= '0;
            bin_out    <= '0;
            bin_valid  <= 1'b0;
            step_ok    <= 1'b0;
            wrap       <= 1'b0;
            hold       <= 1'b0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_n;
            good_run   <= good_run_n;
            v1         <= sample_en;
            g_q        <= sample_en ? gray_in : g_q;
            prev_bin   <= v1 ? b : prev_bin;
            bin_out    <= v1 ? b : bin_out;
            bin_valid  <= v1;
            step_ok    <= is_step;
            wrap       <= is_step && prev_bin == '1;
            hold       <= is_hold;
            step_err   <= is_err;
            // a coincident error beats clr_err
            err_sticky <= is_err || (err_sticky && !clr_err);
            err_count  <= is_err ? (clr_err ? ERR_CNT_W'(1) : (err_count == '1 ? err_count : err_count + ERR_CNT_W'(1)))
                                 : (clr_err ? '0 : err_count);
        end
    end
endmodule

// File: tb/tb_gray_decode_monitor.sv
// tb_gray_decode_monitor: directed and random stimulus against a behavioural reference model
module tb_gray_decode_monitor;
    localparam int N = 8, RL = 4, EW = 3;
    logic clk = 1'b0, rst = 1'b1, sample_en = 1'b0, clr_err = 1'b0;
    logic [N-1:0] gray_in = '0, bin_out;
    logic bin_valid, step_ok, wrap, hold, step_err, locked, err_sticky;
    logic [EW-1:0] err_count;
    int checks = 0, failures = 0, nwrap = 0, nstep = 0;
    bit pend_v;
    logic [7:0] pend_g;
    int m_phase, m_run, m_prev;
    int e_bin, e_valid, e_step, e_wrap, e_hold, e_err, e_sticky, e_cnt;

    gray_decode_monitor #(.N(N), .RESYNC_LEN(RL), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .gray_in(gray_in), .clr_err(clr_err),
        .bin_out(bin_out), .bin_valid(bin_valid), .step_ok(step_ok), .wrap(wrap), .hold(hold),
        .step_err(step_err), .locked(locked), .err_sticky(err_sticky), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_gray(int v);
        return 8'(v ^ (v >> 1));
    endfunction

    function automatic int to_bin(logic [7:0] g);
        int r = 0;
        for (int s = 0; s < 8; s++) r = r ^ (int'(g) >> s);
        return r;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input bit se, input logic [7:0] g, input bit ce, input bit r);
        int d;
        sample_en = se; gray_in = g; clr_err = ce; rst = r;
        @(posedge clk);
        e_valid = 0; e_step = 0; e_wrap = 0; e_hold = 0; e_err = 0;
        if (r) begin
            pend_v = 0; m_phase = 0; m_run = 0; m_prev = 0;
            e_bin = 0; e_sticky = 0; e_cnt = 0;
        end else begin
            if (pend_v) begin
                e_valid = 1;
                e_bin = to_bin(pend_g);
                if (m_phase != 0) begin
                    d = (e_bin - m_prev + 256) % 256;
                    e_hold = d == 0;
                    e_step = d == 1;
                    e_wrap = e_step && m_prev == 255;
                    e_err = d > 1;
                end
                if (m_phase == 0) m_phase = 1;
                else if (e_err) begin m_phase = 2; m_run = 0; end
                else if (m_phase == 2 && e_step) begin
                    m_run++;
                    if (m_run == RL) begin m_phase = 1; m_run = 0; end
                end
                m_prev = e_bin;
            end
            if (e_err) begin
                e_sticky = 1;
                e_cnt = ce ? 1 : (e_cnt == 7 ? 7 : e_cnt + 1);
            end else if (ce) begin
                e_sticky = 0; e_cnt = 0;
            end
            pend_v = se; pend_g = g;
        end
        #1;
        check("bin_valid", bin_valid, e_valid);
        check("bin_out", bin_out, e_bin);
        check("step_ok", step_ok, e_step);
        check("wrap", wrap, e_wrap);
        check("hold", hold, e_hold);
        check("step_err", step_err, e_err);
        check("locked", locked, m_phase == 1);
        check("err_sticky", err_sticky, e_sticky);
        check("err_count", err_count, e_cnt);
        nwrap += wrap;
        nstep += step_ok;
    endtask

    task automatic samp(input int v, input bit ce);
        tick(1'b1, to_gray(v), ce, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic reset;
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        int cur;
        reset();
        nwrap = 0; nstep = 0;
        for (int i = 0; i < 258; i++) begin samp(i % 256, 1'b0); idle(3); end
        check("t1_wraps", nwrap, 1);
        check("t1_steps", nstep, 257);
        reset();
        nstep = 0;
        tick(1'b1, 8'h00, 0, 0); tick(1'b1, 8'h01, 0, 0); tick(1'b1, 8'h03, 0, 0); tick(1'b1, 8'h02, 0, 0);
        idle(3);
        check("t2_steps", nstep, 3);
        reset();
        tick(1'b1, 8'h03, 0, 0); tick(1'b1, 8'h03, 0, 0); idle(3);
        reset();
        for (int i = 0; i <= 5; i++) samp(i, 0);
        samp(9, 0); samp(10, 0); samp(11, 0); samp(12, 0); samp(20, 0);
        for (int i = 21; i <= 24; i++) samp(i, 0);
        idle(3);
        check("t4_locked", locked, 1);
        check("t4_count", err_count, 2);
        reset();
        for (int i = 0; i < 10; i++) samp(i * 37 + 5, 0);
        idle(3);
        check("t5_sat", err_count, 7);
        samp(100, 0); tick(1'b0, 8'h00, 1'b1, 1'b0); idle(2);
        check("t5_clr_count", err_count, 1);
        check("t5_clr_sticky", err_sticky, 1);
        reset();
        samp(3, 0); tick(1'b0, 8'h00, 0, 1); idle(3);
        samp(77, 0); idle(3);
        check("t6_locked", locked, 1);
        cur = 0;
        for (int c = 0; c < 4000; c++) begin
            int r = $urandom_range(0, 15);
            if ($urandom_range(0, 299) == 0) begin tick(1'b0, 8'h00, 1'b0, 1'b1); continue; end
            if (r < 7) cur = (cur + 1) % 256;
            else if (r == 7) cur = $urandom_range(0, 255);
            tick(r < 10, to_gray(cur), $urandom_range(0, 19) == 0, 1'b0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
